// File: rtl/aether_engine_cmd_issuer.sv
// Host-side command issuer for the Aether engine: FIFO-buffers 24-bit command words, issues each for one cycle, returns one response per command.
// Optional timeout counter is compiled in with `define AETHER_ISSUER_TIMEOUT_EN.
module aether_engine_cmd_issuer #(
    parameter int unsigned CMD_DEPTH      = 4,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [23:0] cmd_data_i,
    output logic [3:0]  instruction_o,
    output logic [3:0]  param_1_o,
    output logic [15:0] param_2_o,
    input  logic [15:0] data_i,
    input  logic        engine_busy_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [15:0] rsp_data_o,
    output logic [1:0]  rsp_status_o,
    output logic        idle_o
);

    // Local copy of the aether_constants opcode encoding.
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_RST = 4'h1;
    localparam logic [3:0] OP_RDR = 4'h2;
    localparam logic [3:0] OP_WRR = 4'h3;
    localparam logic [3:0] OP_LDW = 4'h4;
    localparam logic [3:0] OP_CNV = 4'h5;
    localparam logic [3:0] OP_DNS = 4'h6;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_ILLEGAL = 2'b10;

    localparam int unsigned AW = $clog2(CMD_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_START,
        S_WAIT_DONE,
        S_RESP
    } state_t;

    function automatic logic is_legal(input logic [3:0] op);
        return op <= OP_DNS;
    endfunction

    // ---------------- command FIFO ----------------
    logic [23:0] mem_q [CMD_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        fifo_empty, fifo_full, push, pop;
    logic [23:0] head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push       = cmd_valid_i && !fifo_full;
    assign head       = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= cmd_data_i;
    end

    // ---------------- FSM and registered outputs ----------------
    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [3:0]  instr_q, instr_d;
    logic [3:0]  p1_q, p1_d;
    logic [15:0] p2_q, p2_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic [1:0]  rsp_status_q, rsp_status_d;
    logic        waiting, timeout_hit;

    assign waiting = (state_q == S_WAIT_START) || (state_q == S_WAIT_DONE);

`ifdef AETHER_ISSUER_TIMEOUT_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == S_ISSUE)  tmo_cnt_d = '0;
        else if (waiting)        tmo_cnt_d = tmo_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) tmo_cnt_q <= '0;
        else         tmo_cnt_q <= tmo_cnt_d;
    end

    // Fires on the cycle whose increment would make the count reach the limit.
    assign timeout_hit = waiting && ((tmo_cnt_q + 16'd1) == TIMEOUT_CYCLES);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        instr_d      = OP_NOP;
        p1_d         = 4'h0;
        p2_d         = 16'h0000;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        pop          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop  = 1'b1;
                    op_d = head[23:20];
                    if (is_legal(head[23:20])) begin
                        state_d = S_ISSUE;
                        instr_d = head[23:20];
                        p1_d    = head[19:16];
                        p2_d    = head[15:0];
                    end else begin
                        state_d      = S_RESP;
                        rsp_valid_d  = 1'b1;
                        rsp_data_d   = 16'h0000;
                        rsp_status_d = ST_ILLEGAL;
                    end
                end
            end
            S_ISSUE: begin
                if (op_q == OP_LDW || op_q == OP_CNV || op_q == OP_DNS) begin
                    state_d = S_WAIT_START;
                end else begin
                    state_d      = S_RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = ST_OK;
                    rsp_data_d   = (op_q == OP_RDR) ? data_i : 16'h0000;
                end
            end
            S_WAIT_START, S_WAIT_DONE: begin
                if (timeout_hit) begin
                    state_d      = S_RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_data_d   = 16'h0000;
                    rsp_status_d = ST_TIMEOUT;
                end else if (state_q == S_WAIT_START) begin
                    if (engine_busy_i) state_d = S_WAIT_DONE;
                end else if (!engine_busy_i) begin
                    state_d      = S_RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_data_d   = 16'h0000;
                    rsp_status_d = ST_OK;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d      = S_IDLE;
                    rsp_valid_d  = 1'b0;
                    rsp_data_d   = 16'h0000;
                    rsp_status_d = ST_OK;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            op_q         <= OP_NOP;
            instr_q      <= OP_NOP;
            p1_q         <= 4'h0;
            p2_q         <= 16'h0000;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= 16'h0000;
            rsp_status_q <= ST_OK;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            instr_q      <= instr_d;
            p1_q         <= p1_d;
            p2_q         <= p2_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    assign cmd_ready_o   = !fifo_full;
    assign instruction_o = instr_q;
    assign param_1_o     = p1_q;
    assign param_2_o     = p2_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_data_o    = rsp_data_q;
    assign rsp_status_o  = rsp_status_q;
    assign idle_o        = (state_q == S_IDLE) && fifo_empty;

endmodule
